// File: rtl/cskipa_pipe.sv
// Parametrised pipelined carry-skip adder with a global-stall valid/ready handshake.
// Define CSKIPA_OVF_EN to add the registered two's-complement overflow output ovf.
module cskipa_pipe #(
  parameter int WIDTH            = 16,
  parameter int BLOCK            = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSKIPA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int BLK = (BLOCK > 0) ? BLOCK : 1;
  localparam int NB  = WIDTH / BLK;
  localparam int BPS = (BLOCKS_PER_STAGE > 0) ? BLOCKS_PER_STAGE : 1;
  localparam int NS  = (NB + BPS - 1) / BPS;

  if ((BLOCK < 1) || (WIDTH % BLK != 0) || (BLOCKS_PER_STAGE < 1)) begin : g_param_check
    $error("cskipa_pipe: WIDTH must be a multiple of BLOCK and BLOCKS_PER_STAGE must be >= 1");
  end

  logic [WIDTH-1:0] a_q   [NS];
  logic [WIDTH-1:0] b_q   [NS];
  logic [WIDTH-1:0] sum_q [NS];
  logic             c_q   [NS];
  logic             vld_q [NS];

  logic [WIDTH-1:0] a_d   [NS];
  logic [WIDTH-1:0] b_d   [NS];
  logic [WIDTH-1:0] sum_d [NS];
  logic             c_d   [NS];
  logic             vld_d [NS];

  logic             advance;
`ifdef CSKIPA_OVF_EN
  logic             ovf_d;
  logic             ovf_q;
`endif

  // Global stall: the whole pipe moves only when the output slot is free or being drained.
  assign advance  = ~vld_q[NS-1] | out_ready;
  assign in_ready = advance;

  for (genvar s = 0; s < NS; s++) begin : g_stage
    localparam int BLO = s * BPS;
    localparam int BHI = ((s + 1) * BPS < NB) ? (s + 1) * BPS : NB;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] sum_loc;
    logic             c_in;
    logic             c_loc;
    logic             vld_in;
    logic             blk_c;
    logic             rip_c;
    logic             prop;
    logic             hs;
`ifdef CSKIPA_OVF_EN
    logic             cmsb_loc;
`endif

    if (s == 0) begin : g_first
      assign a_in   = i_add_term1;
      assign b_in   = i_add_term2;
      assign sum_in = '0;
      assign c_in   = cin;
      assign vld_in = in_valid;
    end else begin : g_next
      assign a_in   = a_q[s-1];
      assign b_in   = b_q[s-1];
      assign sum_in = sum_q[s-1];
      assign c_in   = c_q[s-1];
      assign vld_in = vld_q[s-1];
    end

    // Per block: explicit ripple chain, then the skip mux picks block_cin when fully propagating.
    always_comb begin
      sum_loc = sum_in;
      blk_c   = c_in;
      rip_c   = 1'b0;
      prop    = 1'b0;
      hs      = 1'b0;
`ifdef CSKIPA_OVF_EN
      cmsb_loc = 1'b0;
`endif
      for (int k = BLO; k < BHI; k++) begin
        rip_c = blk_c;
        prop  = 1'b1;
        for (int i = k * BLK; i < (k + 1) * BLK; i++) begin
          hs = a_in[i] ^ b_in[i];
`ifdef CSKIPA_OVF_EN
          if (i == WIDTH - 1) cmsb_loc = rip_c;
`endif
          sum_loc[i] = hs ^ rip_c;
          rip_c      = (a_in[i] & b_in[i]) | (hs & rip_c);
          prop       = prop & hs;
        end
        blk_c = prop ? blk_c : rip_c;
      end
      c_loc = blk_c;
    end

    assign a_d[s]   = a_in;
    assign b_d[s]   = b_in;
    assign sum_d[s] = sum_loc;
    assign c_d[s]   = c_loc;
    assign vld_d[s] = vld_in;

`ifdef CSKIPA_OVF_EN
    if (s == NS - 1) begin : g_ovf
      assign ovf_d = cmsb_loc ^ c_loc;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
        c_q[s]   <= 1'b0;
        vld_q[s] <= 1'b0;
      end
`ifdef CSKIPA_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (advance) begin
      for (int s = 0; s < NS; s++) begin
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        sum_q[s] <= sum_d[s];
        c_q[s]   <= c_d[s];
        vld_q[s] <= vld_d[s];
      end
`ifdef CSKIPA_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  // Operands leaving the final stage have no consumer.
  logic unused_last_ops;
  assign unused_last_ops = ^{a_q[NS-1], b_q[NS-1]};

  assign sum       = sum_q[NS-1];
  assign cout      = c_q[NS-1];
  assign out_valid = vld_q[NS-1];
`ifdef CSKIPA_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
